irq_timer_ctrl: RTL and testbench

- Programmable interrupt source sequencer that drives the interrupt priority encoder's three request inputs.
- Owns the LSPC-style down-counting timer: reload register, mode bits and reload policies.
- Produces TIMER_IRQ and VBL_IRQ as clean stretched pulses (rising edge = request), and RESET_IRQ as a level held from reset until acknowledged.
- Sits between the 68k register decode and the encoder; runs in the CLK domain and advances on the pixel-clock enable.

---
 rtl/irq_timer_pkg.sv | 15 +
 rtl/irq_pulse_stretch.sv | 39 +++
 rtl/irq_timer_ctrl.sv | 118 +++++++++++
 tb/tb_irq_timer_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_timer_pkg.sv
// Shared constants for the interrupt timer controller.
//   MODE_*  : bit positions of the mode fields within the CPU write data.
//   ACK_*   : bit positions within the acknowledge mask.
package irq_timer_pkg;

  localparam int unsigned MODE_EN      = 4;
  localparam int unsigned MODE_RL_WR   = 5;
  localparam int unsigned MODE_RL_VBL  = 6;
  localparam int unsigned MODE_RL_ZERO = 7;

  localparam int unsigned ACK_RESET = 0;
  localparam int unsigned ACK_TIMER = 1;
  localparam int unsigned ACK_VBL   = 2;

endpackage

// File: rtl/irq_pulse_stretch.sv
// Pulse stretcher: a one-cycle TRIG raises OUT on the next edge for IRQ_PULSE cycles.
// A TRIG while OUT is high restarts the length without dropping OUT.
//   CLK   : system clock
//   RESET : synchronous active-high reset
//   TRIG  : start/restart request
//   OUT   : stretched pulse
module irq_pulse_stretch #(
  parameter int unsigned IRQ_PULSE = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic TRIG,
  output logic OUT
);

  localparam int unsigned CntW = $clog2(IRQ_PULSE + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (TRIG) begin
      cnt_d = CntW'(IRQ_PULSE);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign OUT = (cnt_q != '0);

endmodule

// File: rtl/irq_timer_ctrl.sv
// Interrupt source sequencer: down-counting timer with reload policies, stretched
// TIMER_IRQ / VBL_IRQ pulses and a RESET_IRQ level raised once after reset.
//   CLK, RESET             : clock, synchronous active-high reset
//   PCLK_EN                : pixel tick; the timer only advances on it
//   WR_MODE/WR_TIMER_HIGH/WR_TIMER_LOW, DATA : CPU register writes
//   VBLANK_START           : start-of-vblank strobe
//   WR_ACK, ACK_BITS       : acknowledge write (only the reset bit is used here)
//   TIMER_IRQ, VBL_IRQ     : stretched request pulses
//   RESET_IRQ              : reset request level
//   TIMER_COUNT            : current counter value
module irq_timer_ctrl
  import irq_timer_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned IRQ_PULSE = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PCLK_EN,
  input  logic               WR_MODE,
  input  logic               WR_TIMER_HIGH,
  input  logic               WR_TIMER_LOW,
  input  logic [CNT_W/2-1:0] DATA,
  input  logic               VBLANK_START,
  input  logic               WR_ACK,
  input  logic [2:0]         ACK_BITS,
  output logic               TIMER_IRQ,
  output logic               VBL_IRQ,
  output logic               RESET_IRQ,
  output logic [CNT_W-1:0]   TIMER_COUNT
);

  localparam int unsigned HalfW = CNT_W / 2;

  logic             en_q, rl_wr_q, rl_vbl_q, rl_zero_q;
  logic [CNT_W-1:0] reload_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fire;
  logic             raised_q, reset_irq_q;

  // Timer/vblank acknowledges are latched by the downstream encoder.
  logic unused_ack;
  assign unused_ack = ^ACK_BITS[ACK_VBL:ACK_TIMER];

  // Loads take priority over the tick and swallow it, fire included.
  always_comb begin
    count_d = count_q;
    fire    = 1'b0;
    if (WR_TIMER_LOW && rl_wr_q) begin
      count_d = {reload_q[CNT_W-1:HalfW], DATA};
    end else if (VBLANK_START && rl_vbl_q) begin
      count_d = reload_q;
    end else if (PCLK_EN && en_q) begin
      if (count_q == '0) begin
        fire    = 1'b1;
        count_d = rl_zero_q ? reload_q : '1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      en_q      <= 1'b0;
      rl_wr_q   <= 1'b0;
      rl_vbl_q  <= 1'b0;
      rl_zero_q <= 1'b0;
      reload_q  <= '0;
      count_q   <= '0;
    end else begin
      if (WR_MODE) begin
        en_q      <= DATA[MODE_EN];
        rl_wr_q   <= DATA[MODE_RL_WR];
        rl_vbl_q  <= DATA[MODE_RL_VBL];
        rl_zero_q <= DATA[MODE_RL_ZERO];
      end
      if (WR_TIMER_HIGH) reload_q[CNT_W-1:HalfW] <= DATA;
      if (WR_TIMER_LOW)  reload_q[HalfW-1:0]     <= DATA;
      count_q <= count_d;
    end
  end

  // raised_q makes RESET_IRQ a one-shot per reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      raised_q    <= 1'b0;
      reset_irq_q <= 1'b0;
    end else if (!raised_q) begin
      raised_q    <= 1'b1;
      reset_irq_q <= 1'b1;
    end else if (WR_ACK && ACK_BITS[ACK_RESET]) begin
      reset_irq_q <= 1'b0;
    end
  end

  irq_pulse_stretch #(
    .IRQ_PULSE(IRQ_PULSE)
  ) u_timer_stretch (
    .CLK  (CLK),
    .RESET(RESET),
    .TRIG (fire),
    .OUT  (TIMER_IRQ)
  );

  irq_pulse_stretch #(
    .IRQ_PULSE(IRQ_PULSE)
  ) u_vbl_stretch (
    .CLK  (CLK),
    .RESET(RESET),
    .TRIG (VBLANK_START),
    .OUT  (VBL_IRQ)
  );

  assign RESET_IRQ   = reset_irq_q;
  assign TIMER_COUNT = count_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
module tb_irq_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset, pclk_en, wr_mode, wr_high, wr_low, vblank, wr_ack;
  logic [15:0] data;
  logic [2:0]  ack_bits;
  logic        timer_irq, vbl_irq, reset_irq;
  logic [31:0] timer_count;

  int checks = 0;
  int failures = 0;

  irq_timer_ctrl #(
    .CNT_W    (32),
    .IRQ_PULSE(4)
  ) dut (
    .CLK          (clk),
    .RESET        (reset),
    .PCLK_EN      (pclk_en),
    .WR_MODE      (wr_mode),
    .WR_TIMER_HIGH(wr_high),
    .WR_TIMER_LOW (wr_low),
    .DATA         (data),
    .VBLANK_START (vblank),
    .WR_ACK       (wr_ack),
    .ACK_BITS     (ack_bits),
    .TIMER_IRQ    (timer_irq),
    .VBL_IRQ      (vbl_irq),
    .RESET_IRQ    (reset_irq),
    .TIMER_COUNT  (timer_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_mode_t(input logic [7:0] d);
    wr_mode = 1'b1; data = {8'h00, d}; step(); wr_mode = 1'b0;
  endtask

  task automatic wr_high_t(input logic [15:0] d);
    wr_high = 1'b1; data = d; step(); wr_high = 1'b0;
  endtask

  task automatic wr_low_t(input logic [15:0] d);
    wr_low = 1'b1; data = d; step(); wr_low = 1'b0;
  endtask

  task automatic tick();
    pclk_en = 1'b1; step(); pclk_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({reset_irq, timer_irq, vbl_irq} !== 3'b000 || timer_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: irqs=%b count=%h expected irqs=000 count=0",
               {reset_irq, timer_irq, vbl_irq}, timer_count);
    end
    reset = 1'b0;
    step();
    checks++;
    if (reset_irq !== 1'b1) begin
      failures++; $display("FAIL reset_irq_rise: got %b expected 1", reset_irq);
    end
    wr_ack = 1'b1; ack_bits = 3'b110; step(); wr_ack = 1'b0;
    checks++;
    if (reset_irq !== 1'b1) begin
      failures++; $display("FAIL reset_irq_other_ack: got %b expected 1", reset_irq);
    end
    wr_ack = 1'b1; ack_bits = 3'b001; step(); wr_ack = 1'b0; ack_bits = 3'b000;
    checks++;
    if (reset_irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq_ack: got %b expected 0", reset_irq);
    end
    step(); step();
    checks++;
    if (reset_irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq_no_reraise: got %b expected 0", reset_irq);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] exp_cnt;
    logic        exp_irq;
    wr_high_t(16'h0000);
    wr_mode_t(8'h90);
    wr_low_t(16'h0003);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (timer_count !== 32'h0 || timer_irq !== 1'b0) begin
      failures++;
      $display("FAIL periodic_gap: count=%h irq=%b expected count=0 irq=0", timer_count, timer_irq);
    end
    // Tick on every other CLK so consecutive pulses separate: fires at ticks 0,4,8
    // (edges 0,8,16), each pulse high 4 CLK.
    for (int e = 0; e < 24; e++) begin
      pclk_en = (e % 2 == 0); step(); pclk_en = 1'b0;
      exp_cnt = 32'(3 - ((e / 2) % 4));
      exp_irq = ((e % 8) < 4);
      checks++;
      if (timer_count !== exp_cnt || timer_irq !== exp_irq) begin
        failures++;
        $display("FAIL periodic_e%0d: count=%h irq=%b expected count=%h irq=%b",
                 e, timer_count, timer_irq, exp_cnt, exp_irq);
      end
    end
    // Back-to-back ticks: the fire every 4 ticks lands on the falling cycle and
    // extends the pulse, so TIMER_IRQ stays high.
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_cnt = 32'(3 - (j % 4));
      checks++;
      if (timer_count !== exp_cnt || timer_irq !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back_j%0d: count=%h irq=%b expected count=%h irq=1",
                 j, timer_count, timer_irq, exp_cnt);
      end
    end
  endtask

  task automatic test_reload_write();
    do_reset();
    wr_mode_t(8'hB0);
    wr_high_t(16'h0001);
    checks++;
    if (timer_count !== 32'h0) begin
      failures++; $display("FAIL high_write_no_load: count=%h expected 0", timer_count);
    end
    wr_low_t(16'h0002);
    checks++;
    if (timer_count !== 32'h00010002) begin
      failures++; $display("FAIL low_write_load: count=%h expected 00010002", timer_count);
    end
    wr_low = 1'b1; data = 16'h0002; pclk_en = 1'b1; step(); wr_low = 1'b0; pclk_en = 1'b0;
    checks++;
    if (timer_count !== 32'h00010002) begin
      failures++; $display("FAIL load_beats_tick: count=%h expected 00010002", timer_count);
    end
    tick();
    checks++;
    if (timer_count !== 32'h00010001) begin
      failures++; $display("FAIL tick_after_load: count=%h expected 00010001", timer_count);
    end
  endtask

  task automatic test_wrap();
    int   rises;
    logic prev;
    do_reset();
    wr_mode_t(8'h30);
    wr_high_t(16'h0000);
    wr_low_t(16'h0002);
    wr_mode_t(8'h10);
    tick(); tick();
    checks++;
    if (timer_count !== 32'h0 || timer_irq !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pre: count=%h irq=%b expected count=0 irq=0", timer_count, timer_irq);
    end
    tick();
    checks++;
    if (timer_count !== 32'hFFFFFFFF || timer_irq !== 1'b1) begin
      failures++;
      $display("FAIL wrap_fire: count=%h irq=%b expected count=ffffffff irq=1",
               timer_count, timer_irq);
    end
    rises = 0;
    prev  = timer_irq;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!prev && timer_irq) rises++;
      prev = timer_irq;
    end
    checks++;
    if (rises !== 0 || timer_count !== 32'hFFFFFF9B) begin
      failures++;
      $display("FAIL wrap_run: rises=%0d count=%h expected rises=0 count=ffffff9b",
               rises, timer_count);
    end
  endtask

  task automatic test_vbl();
    logic exp_irq;
    do_reset();
    wr_mode_t(8'h70);
    wr_high_t(16'h0000);
    wr_low_t(16'h0002);
    wr_mode_t(8'h50);
    wr_low_t(16'h0005);
    checks++;
    if (timer_count !== 32'h2) begin
      failures++; $display("FAIL vbl_setup: count=%h expected 2", timer_count);
    end
    vblank = 1'b1; pclk_en = 1'b1; step(); vblank = 1'b0; pclk_en = 1'b0;
    checks++;
    if (timer_count !== 32'h5 || vbl_irq !== 1'b1 || timer_irq !== 1'b0) begin
      failures++;
      $display("FAIL vbl_reload: count=%h vbl=%b tmr=%b expected count=5 vbl=1 tmr=0",
               timer_count, vbl_irq, timer_irq);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_irq = (i < 4);
      checks++;
      if (vbl_irq !== exp_irq || timer_irq !== 1'b0) begin
        failures++;
        $display("FAIL vbl_width_%0d: vbl=%b tmr=%b expected vbl=%b tmr=0",
                 i, vbl_irq, timer_irq, exp_irq);
      end
    end
    // Count at zero: the vblank load must swallow the tick's fire.
    wr_mode_t(8'h70);
    wr_low_t(16'h0000);
    vblank = 1'b1; pclk_en = 1'b1; step(); vblank = 1'b0; pclk_en = 1'b0;
    step();
    checks++;
    if (timer_count !== 32'h0 || timer_irq !== 1'b0) begin
      failures++;
      $display("FAIL vbl_suppress_fire: count=%h tmr=%b expected count=0 tmr=0",
               timer_count, timer_irq);
    end
    // Two VBLANK_START 2 cycles apart with the timer disabled: one 6-cycle pulse.
    wr_mode_t(8'h00);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i <= 6; i++) begin
      vblank = (i == 0 || i == 2); step(); vblank = 1'b0;
      exp_irq = (i <= 5);
      checks++;
      if (vbl_irq !== exp_irq) begin
        failures++; $display("FAIL vbl_retrig_%0d: vbl=%b expected %b", i, vbl_irq, exp_irq);
      end
    end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    wr_mode_t(8'h30);
    wr_low_t(16'h0007);
    wr_mode_t(8'h20);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (timer_count !== 32'h7) begin
      failures++; $display("FAIL freeze: count=%h expected 7", timer_count);
    end
    wr_low_t(16'h0009);
    checks++;
    if (timer_count !== 32'h9) begin
      failures++; $display("FAIL frozen_load: count=%h expected 9", timer_count);
    end
    wr_mode_t(8'hB0);
    wr_low_t(16'h0000);
    tick();
    step();
    checks++;
    if (timer_irq !== 1'b1) begin
      failures++; $display("FAIL pre_reset_irq: tmr=%b expected 1", timer_irq);
    end
    reset = 1'b1; step();
    checks++;
    if (timer_irq !== 1'b0 || timer_count !== 32'h0 || reset_irq !== 1'b0) begin
      failures++;
      $display("FAIL mid_pulse_reset: tmr=%b count=%h rst_irq=%b expected 0/0/0",
               timer_irq, timer_count, reset_irq);
    end
    reset = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1; pclk_en = 1'b0; wr_mode = 1'b0; wr_high = 1'b0; wr_low = 1'b0;
    vblank = 1'b0; wr_ack = 1'b0; ack_bits = 3'b000; data = 16'h0000;
    test_reset();
    test_periodic();
    test_reload_write();
    test_wrap();
    test_vbl();
    test_freeze_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
